// File: rtl/melee_wpn_anim_ctl.sv
// Melee weapon swing animation controller: click -> extend/hold/retract/cooldown.
// Ports: clk, rst (sync, high), vsync, mouse_left, player_flip in;
//   mouse_clicked, anim_x_offset[11:0], flip_hor_melee, hit_pulse, busy out.
module melee_wpn_anim_ctl #(
  parameter int STEP_PX         = 2,
  parameter int RET_STEP_PX     = 2,
  parameter int EXTEND_FRAMES   = 8,
  parameter int HOLD_FRAMES     = 4,
  parameter int COOLDOWN_FRAMES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        mouse_left,
  input  logic        player_flip,
  output logic        mouse_clicked,
  output logic [11:0] anim_x_offset,
  output logic        flip_hor_melee,
  output logic        hit_pulse,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    EXTEND,
    HOLD,
    RETRACT,
    COOLDOWN
  } state_t;

  localparam logic [11:0] STEP     = 12'(STEP_PX);
  localparam logic [11:0] RET_STEP = 12'(RET_STEP_PX);
  localparam logic [15:0] EXT_LAST = 16'(EXTEND_FRAMES - 1);
  localparam logic [15:0] HLD_LAST = 16'(HOLD_FRAMES - 1);
  localparam logic [15:0] CD_LAST  = 16'(COOLDOWN_FRAMES - 1);

  state_t      state;
  state_t      state_n;
  logic [15:0] cnt;
  logic [15:0] cnt_n;
  logic [11:0] off_n;
  logic [11:0] ret_off;
  logic        clicked_n;
  logic        flip_n;
  logic        hit_n;
  logic        vsync_q;
  logic        mouse_q;
  logic        tick;
  logic        click_edge;

  assign tick       = vsync & ~vsync_q;
  assign click_edge = mouse_left & ~mouse_q;

  // Saturating retract so a step larger than the remainder lands on 0.
  assign ret_off = (anim_x_offset > RET_STEP) ?
                   anim_x_offset - RET_STEP : 12'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      anim_x_offset  <= '0;
      mouse_clicked  <= 1'b0;
      flip_hor_melee <= 1'b0;
      hit_pulse      <= 1'b0;
      busy           <= 1'b0;
      vsync_q        <= 1'b0;
      mouse_q        <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      anim_x_offset  <= off_n;
      mouse_clicked  <= clicked_n;
      flip_hor_melee <= flip_n;
      hit_pulse      <= hit_n;
      busy           <= (state_n != IDLE);
      vsync_q        <= vsync;
      mouse_q        <= mouse_left;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    off_n     = anim_x_offset;
    clicked_n = mouse_clicked;
    flip_n    = flip_hor_melee;
    hit_n     = 1'b0;
    unique case (state)
      IDLE: begin
        flip_n = player_flip;
        // A tick coincident with the click is deliberately not counted.
        if (click_edge) begin
          state_n   = EXTEND;
          clicked_n = 1'b1;
          cnt_n     = '0;
        end
      end
      EXTEND: begin
        if (tick) begin
          off_n = anim_x_offset + STEP;
          if (cnt == EXT_LAST) begin
            state_n = HOLD;
            cnt_n   = '0;
            hit_n   = 1'b1;
          end else begin
            cnt_n = cnt + 16'd1;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          if (cnt == HLD_LAST) begin
            state_n = RETRACT;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 16'd1;
          end
        end
      end
      RETRACT: begin
        if (tick) begin
          off_n = ret_off;
          if (ret_off == 12'd0) begin
            state_n   = COOLDOWN;
            clicked_n = 1'b0;
            cnt_n     = '0;
          end
        end
      end
      COOLDOWN: begin
        if (COOLDOWN_FRAMES == 0) begin
          state_n = IDLE;
        end else if (tick) begin
          if (cnt == CD_LAST) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 16'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_melee_wpn_anim_ctl.sv
// Bench for melee_wpn_anim_ctl: vector table with scoreboard queue,
// plus hand sequences for mid-swing reset and saturating retract.
module tb_melee_wpn_anim_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        vsync;
  logic        mouse_left;
  logic        player_flip;
  logic        mc;
  logic [11:0] off;
  logic        fl;
  logic        hp;
  logic        bz;
  logic        mc2;
  logic [11:0] off2;
  logic        fl2;
  logic        hp2;
  logic        bz2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  melee_wpn_anim_ctl dut (
    .clk(clk), .rst(rst), .vsync(vsync),
    .mouse_left(mouse_left), .player_flip(player_flip),
    .mouse_clicked(mc), .anim_x_offset(off),
    .flip_hor_melee(fl), .hit_pulse(hp), .busy(bz)
  );

  melee_wpn_anim_ctl #(.RET_STEP_PX(3)) dut2 (
    .clk(clk), .rst(rst), .vsync(vsync),
    .mouse_left(mouse_left), .player_flip(player_flip),
    .mouse_clicked(mc2), .anim_x_offset(off2),
    .flip_hor_melee(fl2), .hit_pulse(hp2), .busy(bz2)
  );

  typedef struct {
    logic        m;
    logic        f;
    logic        v;
    logic        mc;
    logic [11:0] off;
    logic        fl;
    logic        hp;
    logic        bz;
  } vec_t;

  typedef struct {
    logic        mc;
    logic [11:0] off;
    logic        fl;
    logic        hp;
    logic        bz;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  logic        bm;
  logic        bf;
  logic        e_mc;
  logic        e_fl;
  logic        e_bz;
  logic [11:0] e_off;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic cyc(input logic m, input logic f,
                     input logic v, input logic r);
    mouse_left  = m;
    player_flip = f;
    vsync       = v;
    rst         = r;
    @(posedge clk);
    #1;
  endtask

  task automatic htick(input logic f);
    cyc(1'b0, f, 1'b0, 1'b0);
    cyc(1'b0, f, 1'b1, 1'b0);
  endtask

  function automatic void push(input logic v, input logic hit);
    vec_t t;
    t.m   = bm;
    t.f   = bf;
    t.v   = v;
    t.mc  = e_mc;
    t.off = e_off;
    t.fl  = e_fl;
    t.hp  = hit;
    t.bz  = e_bz;
    tbl.push_back(t);
  endfunction

  function automatic void idle(input int n);
    for (int i = 0; i < n; i++) begin
      e_fl = bf;
      push(1'b0, 1'b0);
    end
  endfunction

  function automatic void tick(input logic [11:0] o, input logic c,
                               input logic b, input logic hit);
    push(1'b0, 1'b0);
    e_off = o;
    e_mc  = c;
    e_bz  = b;
    push(1'b1, hit);
  endfunction

  function automatic void poke();
    bm = 1'b1;
    push(1'b0, 1'b0);
    bm = 1'b0;
    push(1'b0, 1'b0);
  endfunction

  function automatic void swing(input logic fv, input bit pokes,
                                input bit toggle, input bit hold_btn,
                                input bit coinc);
    bf = fv;
    idle(1);
    bm   = 1'b1;
    e_mc = 1'b1;
    e_bz = 1'b1;
    e_fl = bf;
    push(logic'(coinc), 1'b0);
    bm = 1'b0;
    push(1'b0, 1'b0);
    if (toggle) bf = ~bf;
    for (int k = 1; k <= 8; k++) begin
      tick(12'(2 * k), 1'b1, 1'b1, k == 8);
      if (pokes && k == 3) poke();
    end
    if (pokes) poke();
    for (int k = 1; k <= 4; k++) tick(12'd16, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) tick(12'(16 - 2 * k), k != 8, 1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      if (pokes && k == 5) poke();
      if (hold_btn && k == 9) bm = 1'b1;
      tick(12'd0, 1'b0, k != 10, 1'b0);
    end
  endfunction

  initial begin
    mouse_left  = 1'b0;
    player_flip = 1'b0;
    vsync       = 1'b0;
    rst         = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst mc", 32'(mc), 0);
    chk("rst off", 32'(off), 0);
    chk("rst fl", 32'(fl), 0);
    chk("rst hp", 32'(hp), 0);
    chk("rst bz", 32'(bz), 0);

    bm = 1'b0; bf = 1'b0;
    e_mc = 1'b0; e_fl = 1'b0; e_bz = 1'b0; e_off = '0;
    swing(1'b0, 0, 0, 0, 0);
    idle(1);
    swing(1'b1, 0, 1, 0, 0);
    idle(1);
    bf = 1'b1;
    idle(1);
    bf = 1'b0;
    idle(1);
    swing(1'b0, 1, 0, 1, 0);
    idle(3);
    bm = 1'b0;
    idle(1);
    swing(1'b1, 0, 0, 0, 1);
    idle(2);

    foreach (tbl[i]) begin
      exp_t e;
      e.mc  = tbl[i].mc;
      e.off = tbl[i].off;
      e.fl  = tbl[i].fl;
      e.hp  = tbl[i].hp;
      e.bz  = tbl[i].bz;
      sb.push_back(e);
      cyc(tbl[i].m, tbl[i].f, tbl[i].v, 1'b0);
      e = sb.pop_front();
      chk($sformatf("v%0d mc", i), 32'(mc), 32'(e.mc));
      chk($sformatf("v%0d off", i), 32'(off), 32'(e.off));
      chk($sformatf("v%0d fl", i), 32'(fl), 32'(e.fl));
      chk($sformatf("v%0d hp", i), 32'(hp), 32'(e.hp));
      chk($sformatf("v%0d bz", i), 32'(bz), 32'(e.bz));
    end

    // Reset asserted while holding at full extension.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) htick(1'b0);
    htick(1'b0);
    htick(1'b0);
    chk("hold off", 32'(off), 16);
    chk("hold mc", 32'(mc), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("mrst mc", 32'(mc), 0);
    chk("mrst off", 32'(off), 0);
    chk("mrst fl", 32'(fl), 0);
    chk("mrst hp", 32'(hp), 0);
    chk("mrst bz", 32'(bz), 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("post idle bz", 32'(bz), 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("reclick mc", 32'(mc), 1);
    chk("reclick bz", 32'(bz), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    htick(1'b0);
    chk("reclick off", 32'(off), 2);

    // Retract step 3 against extend step 2 saturates at zero.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("r3 rst off", 32'(off2), 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) htick(1'b0);
    chk("r3 ext off", 32'(off2), 16);
    for (int k = 0; k < 4; k++) htick(1'b0);
    chk("r3 hold off", 32'(off2), 16);
    for (int k = 0; k < 6; k++) begin
      logic [11:0] exp_ret [6];
      exp_ret = '{12'd13, 12'd10, 12'd7, 12'd4, 12'd1, 12'd0};
      htick(1'b0);
      chk($sformatf("r3 ret%0d off", k), 32'(off2), 32'(exp_ret[k]));
      chk($sformatf("r3 ret%0d mc", k), 32'(mc2), (k < 5) ? 1 : 0);
      chk($sformatf("r3 ret%0d bz", k), 32'(bz2), 1);
    end
    htick(1'b0);
    chk("r3 cd off", 32'(off2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
